// File: rtl/led_pattern_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

  localparam int unsigned MODE_W    = 2;
  localparam int unsigned PAT_MAX_W = 32;

  typedef enum logic [MODE_W-1:0] {
    MODE_BLINK  = 2'd0,
    MODE_WALK   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  // Pattern loaded on entry to a mode; callers truncate to the ring width.
  function automatic logic [PAT_MAX_W-1:0] init_pattern(input mode_e m);
    case (m)
      MODE_WALK, MODE_BOUNCE: init_pattern = PAT_MAX_W'(1);
      default:                init_pattern = '0;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// Button/switch inputs and LED/seconds outputs of the pattern sequencer.
interface led_seq_if
  import led_seq_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned SEC_W    = 6
) ();

  logic                mode_btn;
  logic                pause;
  logic [NUM_LEDS-1:0] led_ring;
  logic                led_center;
  logic [MODE_W-1:0]   mode;
  logic [SEC_W-1:0]    sec_count;
  logic                sec_wrap;

  modport master (
    output mode_btn, pause,
    input  led_ring, led_center, mode, sec_count, sec_wrap
  );

  modport slave (
    input  mode_btn, pause,
    output led_ring, led_center, mode, sec_count, sec_wrap
  );

endinterface

// File: rtl/led_pattern_seq_btn_sync.sv
// Two-flop synchroniser for a raw async input, optionally reduced to a
// one-cycle rising-edge pulse.
module btn_sync #(
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q_c
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  generate
    if (EDGE_EN) begin : g_edge
      logic prev;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= s2;
      end

      assign q_c = s2 & ~prev;
    end else begin : g_level
      assign q_c = s2;
    end
  endgenerate

endmodule

// File: rtl/led_pattern_seq.sv
// Mode-selectable ring LED pattern, heartbeat LED and seconds counter,
// all advanced once per 1 Hz tick.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned SEC_WRAP = 60,
  parameter int unsigned SEC_W    = $clog2(SEC_WRAP)
) (
  input  logic      clk_tick,
  input  logic      rst,
  led_seq_if.slave  bus
);

  logic                press;
  logic                paused;
  mode_e               mode_q;
  mode_e               mode_nxt;
  logic [NUM_LEDS-1:0] ring_q;
  logic [NUM_LEDS-1:0] step;
  logic                dir_up_q;
  logic                step_dir_up;
  logic                center_q;
  logic [SEC_W-1:0]    sec_q;
  logic                wrap_q;

  btn_sync #(.EDGE_EN(1'b1)) u_btn_sync (
    .clk (clk_tick),
    .rst (rst),
    .din (bus.mode_btn),
    .q_c (press)
  );

  btn_sync #(.EDGE_EN(1'b0)) u_pause_sync (
    .clk (clk_tick),
    .rst (rst),
    .din (bus.pause),
    .q_c (paused)
  );

  assign mode_nxt = mode_e'(mode_q + MODE_W'(1));

  // One pattern step for the current mode; bounce turns at either end.
  always_comb begin
    step        = ring_q;
    step_dir_up = dir_up_q;
    case (mode_q)
      MODE_BLINK: step = ~ring_q;
      MODE_WALK:  step = {ring_q[NUM_LEDS-2:0], ring_q[NUM_LEDS-1]};
      MODE_BOUNCE: begin
        step = dir_up_q ? (ring_q << 1) : (ring_q >> 1);
        if (step[NUM_LEDS-1]) step_dir_up = 1'b0;
        else if (step[0])     step_dir_up = 1'b1;
      end
      default:    step = ring_q + NUM_LEDS'(1);
    endcase
  end

  always_ff @(posedge clk_tick or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_BLINK;
      ring_q   <= '0;
      dir_up_q <= 1'b1;
      center_q <= 1'b0;
      sec_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      // A press wins over pause and over the normal advance.
      if (press) begin
        mode_q   <= mode_nxt;
        ring_q   <= NUM_LEDS'(init_pattern(mode_nxt));
        dir_up_q <= 1'b1;
        center_q <= center_q | paused;
      end else if (paused) begin
        center_q <= 1'b1;
      end else begin
        ring_q   <= step;
        dir_up_q <= step_dir_up;
        center_q <= ~center_q;
      end

      if (paused) begin
        wrap_q <= 1'b0;
      end else if (sec_q == SEC_W'(SEC_WRAP - 1)) begin
        sec_q  <= '0;
        wrap_q <= 1'b1;
      end else begin
        sec_q  <= sec_q + SEC_W'(1);
        wrap_q <= 1'b0;
      end
    end
  end

  assign bus.led_ring   = ring_q;
  assign bus.led_center = center_q;
  assign bus.mode       = mode_q;
  assign bus.sec_count  = sec_q;
  assign bus.sec_wrap   = wrap_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Vector table plus hand-written sequences for the LED pattern sequencer;
// expected outputs are queued with each stimulus and checked after the edge.
module tb_led_pattern_seq;

  localparam int unsigned NL = 4;
  localparam int unsigned SW = 6;

  logic clk_tick = 1'b0;
  logic rst;

  led_seq_if #(.NUM_LEDS(NL), .SEC_W(SW)) bus ();

  led_pattern_seq #(.NUM_LEDS(NL), .SEC_WRAP(60), .SEC_W(SW)) dut (
    .clk_tick (clk_tick),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_tick = ~clk_tick;

  typedef struct {
    logic          btn;
    logic          pause;
    logic [NL-1:0] ring;
    logic          center;
    logic [1:0]    mode;
    logic [SW-1:0] sec;
    logic          wrap;
  } vec_t;

  vec_t tbl[25];
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_no = 0;

  function automatic vec_t mk(input logic b, input logic p, input logic [NL-1:0] r,
                              input logic c, input logic [1:0] m, input int s,
                              input logic w);
    vec_t v;
    v.btn = b; v.pause = p; v.ring = r; v.center = c;
    v.mode = m; v.sec = SW'(s); v.wrap = w;
    return v;
  endfunction

  task automatic compare(input string name, input vec_t e);
    n_tests++;
    if (bus.led_ring !== e.ring || bus.led_center !== e.center || bus.mode !== e.mode ||
        bus.sec_count !== e.sec || bus.sec_wrap !== e.wrap) begin
      n_fail++;
      $display("FAIL %s: got ring=%b center=%b mode=%0d sec=%0d wrap=%b, want ring=%b center=%b mode=%0d sec=%0d wrap=%b",
               name, bus.led_ring, bus.led_center, bus.mode, bus.sec_count, bus.sec_wrap,
               e.ring, e.center, e.mode, e.sec, e.wrap);
    end
  endtask

  // Drive inputs, queue the expectation, and check it one edge later.
  task automatic step(input vec_t v);
    bus.mode_btn = v.btn;
    bus.pause    = v.pause;
    exp_q.push_back(v);
    @(posedge clk_tick);
    #1;
    edge_no++;
    compare($sformatf("edge%0d", edge_no), exp_q.pop_front());
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // BLINK, press into WALK, press into BOUNCE, press into COUNT
    tbl[0]  = mk(0, 0, 4'hF, 1, 0, 1, 0);
    tbl[1]  = mk(0, 0, 4'h0, 0, 0, 2, 0);
    tbl[2]  = mk(0, 0, 4'hF, 1, 0, 3, 0);
    tbl[3]  = mk(0, 0, 4'h0, 0, 0, 4, 0);
    tbl[4]  = mk(0, 0, 4'hF, 1, 0, 5, 0);
    tbl[5]  = mk(1, 0, 4'h0, 0, 0, 6, 0);
    tbl[6]  = mk(1, 0, 4'hF, 1, 0, 7, 0);
    tbl[7]  = mk(1, 0, 4'h1, 1, 1, 8, 0);
    tbl[8]  = mk(0, 0, 4'h2, 0, 1, 9, 0);
    tbl[9]  = mk(0, 0, 4'h4, 1, 1, 10, 0);
    tbl[10] = mk(0, 0, 4'h8, 0, 1, 11, 0);
    tbl[11] = mk(0, 0, 4'h1, 1, 1, 12, 0);
    tbl[12] = mk(1, 0, 4'h2, 0, 1, 13, 0);
    tbl[13] = mk(1, 0, 4'h4, 1, 1, 14, 0);
    tbl[14] = mk(1, 0, 4'h1, 1, 2, 15, 0);
    tbl[15] = mk(0, 0, 4'h2, 0, 2, 16, 0);
    tbl[16] = mk(0, 0, 4'h4, 1, 2, 17, 0);
    tbl[17] = mk(0, 0, 4'h8, 0, 2, 18, 0);
    tbl[18] = mk(0, 0, 4'h4, 1, 2, 19, 0);
    tbl[19] = mk(0, 0, 4'h2, 0, 2, 20, 0);
    tbl[20] = mk(0, 0, 4'h1, 1, 2, 21, 0);
    tbl[21] = mk(0, 0, 4'h2, 0, 2, 22, 0);
    tbl[22] = mk(1, 0, 4'h4, 1, 2, 23, 0);
    tbl[23] = mk(1, 0, 4'h8, 0, 2, 24, 0);
    tbl[24] = mk(1, 0, 4'h0, 0, 3, 25, 0);

    bus.mode_btn = 1'b0;
    bus.pause    = 1'b0;
    rst          = 1'b1;
    #22;
    compare("reset", mk(0, 0, 4'h0, 0, 0, 0, 0));
    rst = 1'b0;

    for (int i = 0; i < 25; i++) step(tbl[i]);

    // COUNT: 16 advances wrap the ring back to 0000
    for (int j = 1; j <= 16; j++)
      step(mk(0, 0, NL'(j % 16), 1'(j % 2), 3, 25 + j, 0));

    // Fourth press returns to BLINK
    step(mk(1, 0, 4'h1, 1, 3, 42, 0));
    step(mk(1, 0, 4'h2, 0, 3, 43, 0));
    step(mk(1, 0, 4'h0, 0, 0, 44, 0));

    // BLINK across the seconds wrap at edge 60
    for (int j = 1; j <= 18; j++)
      step(mk(0, 0, (j % 2 == 1) ? 4'hF : 4'h0, 1'(j % 2), 0,
              (44 + j) % 60, 1'((44 + j) == 60)));

    // Pause with a press inside it, then release
    step(mk(0, 1, 4'hF, 1, 0, 3, 0));
    step(mk(0, 1, 4'h0, 0, 0, 4, 0));
    step(mk(1, 1, 4'h0, 1, 0, 4, 0));
    step(mk(1, 1, 4'h0, 1, 0, 4, 0));
    step(mk(1, 1, 4'h1, 1, 1, 4, 0));
    step(mk(0, 1, 4'h1, 1, 1, 4, 0));
    step(mk(0, 0, 4'h1, 1, 1, 4, 0));
    step(mk(0, 0, 4'h1, 1, 1, 4, 0));
    step(mk(0, 0, 4'h2, 0, 1, 5, 0));
    step(mk(0, 0, 4'h4, 1, 1, 6, 0));

    // Into BOUNCE and up to 0100 heading down
    step(mk(1, 0, 4'h8, 0, 1, 7, 0));
    step(mk(1, 0, 4'h1, 1, 1, 8, 0));
    step(mk(1, 0, 4'h1, 1, 2, 9, 0));
    step(mk(0, 0, 4'h2, 0, 2, 10, 0));
    step(mk(0, 0, 4'h4, 1, 2, 11, 0));
    step(mk(0, 0, 4'h8, 0, 2, 12, 0));
    step(mk(0, 0, 4'h4, 1, 2, 13, 0));

    // Asynchronous reset between edges, then BLINK resumes
    #2;
    rst = 1'b1;
    #1;
    compare("rst_async", mk(0, 0, 4'h0, 0, 0, 0, 0));
    #1;
    rst = 1'b0;
    step(mk(0, 0, 4'hF, 1, 0, 1, 0));
    step(mk(0, 0, 4'h0, 0, 0, 2, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
